// File: rtl/elink_trig_sum_sched.sv
// elink_trig_sum_sched
// Shares one 4-input elink trigger summer across NGROUP groups of four
// 12-bit trigger words. A bunch-crossing strobe snapshots every group and
// the threshold; groups are then issued to the summer one per cycle, and a
// {valid,group} tag pipeline aligns each result with the summer's latency.
//
// Optional feature macro: ELINK_SCHED_MASK_EN
//   Adds grp_mask; masked groups are skipped and the remaining groups are
//   issued back-to-back in ascending order.
//
// state   | meaning
// S_IDLE  | waiting for bx_strobe, summer operands held at zero
// S_ISSUE | one snapshot group presented to the summer per cycle
// S_DRAIN | last operands issued, waiting SUM_LAT cycles for the results

module elink_trig_sum_sched #(
  parameter int NGROUP  = 4,
  parameter int SUM_LAT = 1,
  parameter int GW      = $clog2(NGROUP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bx_strobe,
  input  logic [NGROUP*48-1:0] grp_data,
  input  logic [12:0]          thr,
`ifdef ELINK_SCHED_MASK_EN
  input  logic [NGROUP-1:0]    grp_mask,
`endif
  output logic [11:0]          sum_in1,
  output logic [11:0]          sum_in2,
  output logic [11:0]          sum_in3,
  output logic [11:0]          sum_in4,
  input  logic [12:0]          sum_out,
  output logic                 out_valid,
  output logic [GW-1:0]        out_group,
  output logic [12:0]          out_sum,
  output logic                 out_over_thr,
  output logic                 busy,
  output logic                 overrun,
  output logic [7:0]           overrun_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t               state;
  logic [NGROUP*48-1:0] snap;
  logic [12:0]          thr_q;
  logic [NGROUP-1:0]    pend;
  logic [2:0]           drain_cnt;
  logic                 iss_valid;
  logic [GW-1:0]        iss_group;
  logic [NGROUP-1:0]    start_mask;
  logic [GW-1:0]        start_grp;
  logic [GW-1:0]        pend_grp;
  logic [SUM_LAT-1:0]   tag_v;
  logic [GW-1:0]        tag_g [SUM_LAT];
  logic [12:0]          sum_hold;

  // lowest-numbered set bit; callers only use it when some bit is set
  function automatic logic [GW-1:0] lowest_set(input logic [NGROUP-1:0] v);
    logic [GW-1:0] idx;
    idx = '0;
    for (int i = NGROUP - 1; i >= 0; i--) begin
      if (v[i]) idx = GW'(i);
    end
    return idx;
  endfunction

`ifdef ELINK_SCHED_MASK_EN
  assign start_mask = grp_mask;
`else
  assign start_mask = '1;
`endif

  assign start_grp = lowest_set(start_mask);
  assign pend_grp  = lowest_set(pend);

  // Schedule FSM: snapshot on strobe, issue pending groups, drain, count drops
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      snap        <= '0;
      thr_q       <= '0;
      pend        <= '0;
      drain_cnt   <= '0;
      iss_valid   <= 1'b0;
      iss_group   <= '0;
      sum_in1     <= '0;
      sum_in2     <= '0;
      sum_in3     <= '0;
      sum_in4     <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      overrun <= 1'b0;
      if (bx_strobe && state != S_IDLE) begin
        overrun <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
      case (state)
        S_IDLE: begin
          iss_valid <= 1'b0;
          {sum_in4, sum_in3, sum_in2, sum_in1} <= '0;
          if (bx_strobe) begin
            snap  <= grp_data;
            thr_q <= thr;
            busy  <= 1'b1;
            if (|start_mask) begin
              // first group goes straight from the input so it issues at t+1
              state     <= S_ISSUE;
              {sum_in4, sum_in3, sum_in2, sum_in1} <= grp_data[start_grp*48 +: 48];
              iss_valid <= 1'b1;
              iss_group <= start_grp;
              pend      <= start_mask & ~(NGROUP'(1) << start_grp);
            end else begin
              // nothing to issue: a single busy cycle, then back to idle
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (|pend) begin
            {sum_in4, sum_in3, sum_in2, sum_in1} <= snap[pend_grp*48 +: 48];
            iss_valid <= 1'b1;
            iss_group <= pend_grp;
            pend      <= pend & ~(NGROUP'(1) << pend_grp);
          end else begin
            {sum_in4, sum_in3, sum_in2, sum_in1} <= '0;
            iss_valid <= 1'b0;
            state     <= S_DRAIN;
            drain_cnt <= 3'(SUM_LAT - 1);
          end
        end
        S_DRAIN: begin
          iss_valid <= 1'b0;
          if (drain_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline matching the summer latency; group tags and sum hold last valid
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v    <= '0;
      sum_hold <= '0;
      for (int i = 0; i < SUM_LAT; i++) tag_g[i] <= '0;
    end else begin
      tag_v[0] <= iss_valid;
      if (iss_valid) tag_g[0] <= iss_group;
      for (int i = 1; i < SUM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        if (tag_v[i-1]) tag_g[i] <= tag_g[i-1];
      end
      if (tag_v[SUM_LAT-1]) sum_hold <= sum_out;
    end
  end

  // The summer result is only present in its valid cycle, so out_sum passes it
  // through then and otherwise shows the last captured value.
  assign out_valid    = tag_v[SUM_LAT-1];
  assign out_group    = tag_g[SUM_LAT-1];
  assign out_sum      = out_valid ? sum_out : sum_hold;
  assign out_over_thr = out_valid && (sum_out >= thr_q);

endmodule
